// File: rtl/deser_bus_scheduler.sv
// deser_bus_scheduler: round-robin shares one deserializer between two serial sources,
// feeding one bit per 100 kHz tick and delivering each byte tagged with its source.
module deser_bus_scheduler #(
   parameter int CLK_DIV       = 10,
   parameter int BYTE_BITS     = 8,
   parameter int TIMEOUT_TICKS = 255
) (
   input  logic                 clock1M,
   input  logic                 reset,
   input  logic                 src0_bit,
   input  logic                 src1_bit,
   input  logic                 src0_valid,
   input  logic                 src1_valid,
   output logic                 src0_ready,
   output logic                 src1_ready,
   output logic                 deser_data_in,
   output logic                 deser_write_in,
   output logic                 deser_ack_in,
   input  logic                 deser_data_ready,
   input  logic [BYTE_BITS-1:0] deser_data_out,
   output logic [BYTE_BITS-1:0] byte_out,
   output logic                 byte_src,
   output logic                 byte_pad,
   output logic                 byte_valid,
   input  logic                 byte_accept,
   output logic                 tick_out,
   output logic                 busy,
   output logic                 timeout_err,
   input  logic                 err_clear
);
   localparam int TW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(BYTE_BITS + 1);
   localparam int OW = $clog2(TIMEOUT_TICKS + 1);

   typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_WAIT_RDY, S_DELIVER, S_ACK, S_WAIT_CLR} state_t;

   state_t        r_state, w_next;
   logic [TW-1:0] r_tick_cnt;
   logic [BW-1:0] r_bit_cnt;
   logic [OW-1:0] r_to_cnt;
   logic          r_grant, r_last_grant, r_pad;
   logic          w_tick, w_any, w_pick, w_gvalid, w_gbit, w_shift_tick;
   logic          w_xfer, w_write, w_last_bit, w_idle_tick, w_to_hit, w_arb;

   assign w_tick       = r_tick_cnt == TW'(CLK_DIV - 1);
   assign w_any        = src0_valid | src1_valid;
   assign w_pick       = (src0_valid & src1_valid) ? ~r_last_grant : src1_valid;
   assign w_arb        = (r_state == S_IDLE) & w_tick & w_any;
   assign w_gvalid     = r_grant ? src1_valid : src0_valid;
   assign w_gbit       = r_grant ? src1_bit : src0_bit;
   assign w_shift_tick = (r_state == S_SHIFT) & w_tick;
   assign w_xfer       = w_shift_tick & ~r_pad & w_gvalid;
   // once padded, every tick pushes a zero without consulting either source
   assign w_write      = w_xfer | (w_shift_tick & r_pad);
   assign w_last_bit   = w_write & (r_bit_cnt == BW'(BYTE_BITS - 1));
   assign w_idle_tick  = w_shift_tick & ~r_pad & ~w_gvalid;
   assign w_to_hit     = w_idle_tick & (r_to_cnt == OW'(TIMEOUT_TICKS - 1));

   assign src0_ready     = w_xfer & ~r_grant;
   assign src1_ready     = w_xfer & r_grant;
   assign deser_write_in = w_write;
   assign deser_data_in  = w_xfer & w_gbit;
   assign deser_ack_in   = r_state == S_ACK;
   assign tick_out       = w_tick;
   assign busy           = r_state != S_IDLE;

   always_ff @(posedge clock1M) begin
      if (reset) r_state <= S_IDLE;
      else r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     w_next = w_arb ? S_SHIFT : S_IDLE;
         S_SHIFT:    w_next = w_last_bit ? S_WAIT_RDY : S_SHIFT;
         S_WAIT_RDY: w_next = deser_data_ready ? S_DELIVER : S_WAIT_RDY;
         S_DELIVER:  w_next = (byte_accept & byte_valid) ? S_ACK : S_DELIVER;
         S_ACK:      w_next = S_WAIT_CLR;
         S_WAIT_CLR: w_next = deser_data_ready ? S_WAIT_CLR : S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock1M) begin
      if (reset) begin
         r_tick_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_to_cnt     <= '0;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_pad        <= 1'b0;
         timeout_err  <= 1'b0;
         byte_out     <= '0;
         byte_src     <= 1'b0;
         byte_pad     <= 1'b0;
         byte_valid   <= 1'b0;
      end else begin
         r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
         timeout_err <= w_to_hit | (timeout_err & ~err_clear);
         if (w_arb) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
         end
         if (w_write) r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
         if (w_xfer) r_to_cnt <= '0;
         else if (w_idle_tick) r_to_cnt <= r_to_cnt + 1'b1;
         if (w_to_hit) r_pad <= 1'b1;
         if (r_state == S_WAIT_RDY && deser_data_ready) begin
            byte_out   <= deser_data_out;
            byte_src   <= r_grant;
            byte_pad   <= r_pad;
            byte_valid <= 1'b1;
         end
         if (r_state == S_DELIVER && byte_accept) byte_valid <= 1'b0;
         if (r_state == S_WAIT_CLR && !deser_data_ready) begin
            r_pad    <= 1'b0;
            r_to_cnt <= '0;
         end
      end
   end
endmodule
